// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: measures per-frame timing and the active-pixel checksum,
// and tracks lock and error status against the nominal mode.
module vga_frame_monitor #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        vga_clk,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank_n,
   input  logic [23:0] rgb,
   output logic [11:0] meas_h_total,
   output logic [11:0] meas_h_active,
   output logic [11:0] meas_v_total,
   output logic [11:0] meas_v_active,
   output logic [31:0] frame_sum,
   output logic        frame_valid,
   output logic        locked,
   output logic [7:0]  err_cnt
);

   localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
   localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
   localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL);
   localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE);
   localparam logic [3:0]  LOCK_N     = 4'(LOCK_FRAMES);

   logic        vga_clk_q, tick, hs_q, vs_q, hs_fall, vs_fall;
   logic        close_q, load_q, seen_first_vsync, first_done;
   logic [11:0] h_cnt, line_act, v_cnt, v_act, h_total_reg, h_act_reg;
   logic [31:0] sum_acc;
   logic [3:0]  match_cnt;
   logic        frame_match;

   logic [11:0] h_cnt_n, line_act_n, v_cnt_n, v_act_n, h_total_n, h_act_n;
   logic [11:0] v_cnt_b, v_act_b;
   logic [31:0] sum_n, sum_b;
   logic        first_n, first_b;

   assign tick    = vga_clk & ~vga_clk_q;
   assign hs_fall = tick & ~hsync & hs_q;
   assign vs_fall = tick & ~vsync & vs_q;

   assign frame_match = (meas_h_total == H_TOTAL_C) && (meas_h_active == H_ACTIVE_C) &&
                        (meas_v_total == V_TOTAL_C) && (meas_v_active == V_ACTIVE_C);

   // Frame counters are cleared on the cycle the outputs load (after the closing tick),
   // so a line close on the same tick as vsync still counts toward the closing frame.
   always_comb begin
      v_cnt_b    = close_q ? '0 : v_cnt;
      v_act_b    = close_q ? '0 : v_act;
      sum_b      = close_q ? '0 : sum_acc;
      first_b    = close_q ? 1'b0 : first_done;
      h_cnt_n    = h_cnt;
      line_act_n = line_act;
      h_total_n  = h_total_reg;
      h_act_n    = h_act_reg;
      v_cnt_n    = v_cnt_b;
      v_act_n    = v_act_b;
      sum_n      = sum_b;
      first_n    = first_b;
      if (tick) begin
         h_cnt_n = (h_cnt == '1) ? h_cnt : h_cnt + 12'd1;
         if (blank_n) begin
            line_act_n = (line_act == '1) ? line_act : line_act + 12'd1;
            sum_n      = sum_b + {8'b0, rgb};
         end
         if (hs_fall) begin
            h_total_n = h_cnt_n;
            h_cnt_n   = '0;
            if (line_act_n != '0) begin
               v_act_n = (v_act_b == '1) ? v_act_b : v_act_b + 12'd1;
               if (!first_b) begin
                  h_act_n = line_act_n;
                  first_n = 1'b1;
               end
            end
            line_act_n = '0;
            v_cnt_n    = (v_cnt_b == '1) ? v_cnt_b : v_cnt_b + 12'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vga_clk_q        <= 1'b0;
         hs_q             <= 1'b1;
         vs_q             <= 1'b1;
         close_q          <= 1'b0;
         load_q           <= 1'b0;
         seen_first_vsync <= 1'b0;
         first_done       <= 1'b0;
         h_cnt            <= '0;
         line_act         <= '0;
         v_cnt            <= '0;
         v_act            <= '0;
         h_total_reg      <= '0;
         h_act_reg        <= '0;
         sum_acc          <= '0;
      end else begin
         vga_clk_q <= vga_clk;
         if (tick) begin
            hs_q <= hsync;
            vs_q <= vsync;
         end
         close_q <= vs_fall;
         load_q  <= vs_fall & seen_first_vsync;
         if (vs_fall)
            seen_first_vsync <= 1'b1;
         first_done  <= first_n;
         h_cnt       <= h_cnt_n;
         line_act    <= line_act_n;
         v_cnt       <= v_cnt_n;
         v_act       <= v_act_n;
         h_total_reg <= h_total_n;
         h_act_reg   <= h_act_n;
         sum_acc     <= sum_n;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         meas_h_total  <= '0;
         meas_h_active <= '0;
         meas_v_total  <= '0;
         meas_v_active <= '0;
         frame_sum     <= '0;
         frame_valid   <= 1'b0;
      end else begin
         frame_valid <= close_q & load_q;
         if (close_q && load_q) begin
            meas_h_total  <= h_total_reg;
            meas_h_active <= h_act_reg;
            meas_v_total  <= v_cnt;
            meas_v_active <= v_act;
            frame_sum     <= sum_acc;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         match_cnt <= '0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else if (frame_valid) begin
         if (frame_match) begin
            if (match_cnt != LOCK_N)
               match_cnt <= match_cnt + 4'd1;
            locked <= (match_cnt >= LOCK_N - 4'd1);
         end else begin
            match_cnt <= '0;
            locked    <= 1'b0;
            if (err_cnt != '1)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: drives a reduced-size video mode and checks each
// frame report, lock and error count against a frame-level reference model.
module tb_vga_frame_monitor;

   localparam int HA = 24, HT = 40, VA = 12, VT = 20, LF = 2;
   localparam int HS_W = 4, VS_W = 2, H_START = 8, V_START = 4;

   typedef struct packed {
      logic [11:0] ht;
      logic [11:0] ha;
      logic [11:0] vt;
      logic [11:0] va;
      logic [31:0] sum;
   } rec_t;

   logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic        vga_clk = 1'b0, hsync = 1'b1, vsync = 1'b1, blank_n = 1'b0;
   logic [23:0] rgb = '0;
   logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
   logic [31:0] frame_sum;
   logic        frame_valid, locked;
   logic [7:0]  err_cnt;

   vga_frame_monitor #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vga_clk(vga_clk),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .rgb(rgb),
      .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
      .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
      .frame_sum(frame_sum), .frame_valid(frame_valid),
      .locked(locked), .err_cnt(err_cnt)
   );

   always #10 sys_clk = ~sys_clk;

   int   n_checks = 0, n_err = 0, fv_seen = 0;
   rec_t obs_q[$], exp_q[$];
   rec_t exp_r, obs_r, cur;

   // reference model state
   bit   m_seen = 0, pend_first = 0;
   rec_t pend = '0, m_last = '0;
   int   m_match = 0, m_nvalid = 0;
   logic m_locked = 1'b0;
   logic [7:0] m_err = '0;

   // stimulus knobs
   int   g_last_extra = 0, g_act_extra = 0;
   bit   g_rand = 0;
   logic [23:0] g_const = 24'hFF0000;

   always @(negedge sys_clk) begin
      if (frame_valid === 1'b1) begin
         cur = {meas_h_total, meas_h_active, meas_v_total, meas_v_active, frame_sum};
         obs_q.push_back(cur);
         fv_seen++;
      end
   end

   initial begin
      #4ms;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1);
   end

   task automatic drive_tick(input logic hs, input logic vs, input logic bn, input logic [23:0] px);
      @(posedge sys_clk); #1;
      vga_clk = 1'b1; hsync = hs; vsync = vs; blank_n = bn; rgb = px;
      @(posedge sys_clk); #1;
      vga_clk = 1'b0;
   endtask

   // A frame opened at y==0 closes the previous one: the model reports it if a vsync was already seen.
   task automatic send_frame(input int first_y, input int last_y);
      int len, act_len, cnt;
      logic hs, vs, bn;
      logic [23:0] px;
      for (int y = first_y; y < last_y; y++) begin
         if (y == 0) begin
            if (m_seen) begin
               exp_q.push_back(pend);
               m_last = pend;
               m_nvalid++;
               if (pend.ht == HT && pend.ha == HA && pend.vt == VT && pend.va == VA) begin
                  m_match  = (m_match < LF) ? m_match + 1 : LF;
                  m_locked = (m_match >= LF);
               end else begin
                  m_match  = 0;
                  m_locked = 1'b0;
                  if (m_err != 8'd255) m_err = m_err + 8'd1;
               end
            end
            m_seen = 1;
            pend = '0;
            pend_first = 0;
         end
         len     = HT + ((y == VT - 1) ? g_last_extra : 0);
         act_len = HA + ((y == V_START) ? g_act_extra : 0);
         cnt     = 0;
         for (int x = 0; x < len; x++) begin
            hs = (x >= HS_W);
            vs = (y >= VS_W);
            bn = (y >= V_START) && (y < V_START + VA) && (x >= H_START) && (x < H_START + act_len);
            px = g_rand ? 24'($urandom) : g_const;
            if (bn) begin
               pend.sum = pend.sum + {8'h00, px};
               cnt++;
            end
            drive_tick(hs, vs, bn, px);
         end
         pend.vt = pend.vt + 12'd1;
         pend.ht = 12'(len);
         if (cnt > 0) begin
            pend.va = pend.va + 12'd1;
            if (!pend_first) begin
               pend.ha = 12'(cnt);
               pend_first = 1;
            end
         end
      end
   endtask

   task automatic test_reset;
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk); sys_rst_n = 1'b1;
      cur = {meas_h_total, meas_h_active, meas_v_total, meas_v_active, frame_sum};
      n_checks++;
      if (cur !== '0) begin n_err++; $display("FAIL reset_meas: got %h expected 0", cur); end
      n_checks++;
      if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
      n_checks++;
      if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked); end
      n_checks++;
      if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_nominal;
      g_rand = 0; g_const = 24'hFF0000;
      send_frame(0, VT);
      n_checks++;
      if (fv_seen !== 0) begin n_err++; $display("FAIL first_vsync_discard: got %0d pulses expected 0", fv_seen); end
      send_frame(0, VT);
      send_frame(0, VT);
      g_const = 24'h000001;
      send_frame(0, VT);
      g_rand = 1;
      send_frame(0, VT);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL nominal_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL nominal_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (locked !== m_locked) begin n_err++; $display("FAIL nominal_locked: got %b expected %b", locked, m_locked); end
      n_checks++;
      if (err_cnt !== m_err) begin n_err++; $display("FAIL nominal_err: got %0d expected %0d", err_cnt, m_err); end
   endtask

   task automatic test_long_line;
      g_last_extra = 1;
      send_frame(0, VT);
      g_last_extra = 0;
      send_frame(0, VT);
      n_checks++;
      if (locked !== 1'b0 || m_locked !== 1'b0) begin n_err++; $display("FAIL long_line_unlock: got %b expected 0", locked); end
      send_frame(0, VT);
      send_frame(0, VT);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL long_line_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL long_line_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (locked !== m_locked) begin n_err++; $display("FAIL long_line_relock: got %b expected %b", locked, m_locked); end
      n_checks++;
      if (err_cnt !== m_err) begin n_err++; $display("FAIL long_line_err: got %0d expected %0d", err_cnt, m_err); end
   endtask

   task automatic test_wide_active;
      g_act_extra = 1;
      send_frame(0, VT);
      g_act_extra = 0;
      send_frame(0, VT);
      send_frame(0, VT);
      send_frame(0, VT);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL wide_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL wide_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (err_cnt !== m_err) begin n_err++; $display("FAIL wide_err: got %0d expected %0d", err_cnt, m_err); end
      n_checks++;
      if (locked !== m_locked) begin n_err++; $display("FAIL wide_locked: got %b expected %b", locked, m_locked); end
   endtask

   task automatic test_stall;
      send_frame(0, 10);
      repeat (2000) @(posedge sys_clk);
      @(negedge sys_clk);
      cur = {meas_h_total, meas_h_active, meas_v_total, meas_v_active, frame_sum};
      n_checks++;
      if (fv_seen !== m_nvalid) begin n_err++; $display("FAIL stall_valid: got %0d pulses expected %0d", fv_seen, m_nvalid); end
      n_checks++;
      if (cur !== m_last) begin n_err++; $display("FAIL stall_hold: got %h expected %h", cur, m_last); end
      n_checks++;
      if (locked !== m_locked || err_cnt !== m_err) begin
         n_err++; $display("FAIL stall_status: got %b/%0d expected %b/%0d", locked, err_cnt, m_locked, m_err);
      end
      send_frame(10, VT);
      send_frame(0, VT);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL stall_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL stall_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (err_cnt !== m_err) begin n_err++; $display("FAIL stall_err: got %0d expected %0d", err_cnt, m_err); end
   endtask

   task automatic test_reset_midframe;
      send_frame(0, 9);
      @(negedge sys_clk); sys_rst_n = 1'b0; #2;
      cur = {meas_h_total, meas_h_active, meas_v_total, meas_v_active, frame_sum};
      n_checks++;
      if (cur !== '0 || locked !== 1'b0 || err_cnt !== 8'd0 || frame_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset_clear: got %h/%b/%0d expected all 0", cur, locked, err_cnt);
      end
      m_seen = 0; m_match = 0; m_locked = 1'b0; m_err = '0; m_last = '0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk); sys_rst_n = 1'b1;
      send_frame(12, VT);
      send_frame(0, VT);
      n_checks++;
      if (fv_seen !== m_nvalid) begin n_err++; $display("FAIL midreset_discard: got %0d pulses expected %0d", fv_seen, m_nvalid); end
      send_frame(0, VT);
      send_frame(0, VT);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL midreset_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL midreset_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (locked !== m_locked) begin n_err++; $display("FAIL midreset_relock: got %b expected %b", locked, m_locked); end
   endtask

   task automatic test_back_to_back;
      g_rand = 1;
      for (int f = 0; f < 5; f++) begin
         g_last_extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         g_act_extra  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         send_frame(0, VT);
      end
      g_last_extra = 0; g_act_extra = 0;
      send_frame(0, 1);
      repeat (4) @(posedge sys_clk);
      while (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front(); n_checks++;
         if (obs_q.size() == 0) begin n_err++; $display("FAIL b2b_rec: none got, expected %h", exp_r); end
         else begin
            obs_r = obs_q.pop_front();
            if (obs_r !== exp_r) begin n_err++; $display("FAIL b2b_rec: got %h expected %h", obs_r, exp_r); end
         end
      end
      n_checks++;
      if (locked !== m_locked) begin n_err++; $display("FAIL b2b_locked: got %b expected %b", locked, m_locked); end
      n_checks++;
      if (err_cnt !== m_err) begin n_err++; $display("FAIL b2b_err: got %0d expected %0d", err_cnt, m_err); end
      n_checks++;
      if (fv_seen !== m_nvalid) begin n_err++; $display("FAIL b2b_count: got %0d pulses expected %0d", fv_seen, m_nvalid); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_long_line();
      test_wide_active();
      test_stall();
      test_reset_midframe();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
